// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit
// Hazard controller for the 5-stage RISC-V core. It provides M/W operand
// forwarding, load-use stall/flush, and a scoreboard for one fixed-latency
// long-operation unit (RAW/WAW/structural). It also freezes the whole pipe
// while data memory waits.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   Rs1D/Rs2D/RdD, RegWriteD, LongOpD                       decode-stage info
//   Rs1E/Rs2E/RdE, RegWriteE, ResultSrcE0, LongOpE, PCSrcE  execute-stage info
//   RdM/RegWriteM, RdW/RegWriteW                            M/W destinations
//   MemStallM                  data memory not ready
//   ForwardAE/ForwardBE        00 RF, 01 W result, 10 M ALU result
//   StallF..StallW, FlushD/E   stage enables and bubbles
//   LongWrEn/LongRdW           long-unit write-back strobe and destination
module hazard_scoreboard_unit #(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned LONG_LAT   = 4,
  parameter int unsigned FORWARD_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] RdD,
  input  logic              RegWriteD,
  input  logic              LongOpD,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic              RegWriteE,
  input  logic              ResultSrcE0,
  input  logic              LongOpE,
  input  logic              PCSrcE,
  input  logic [REG_AW-1:0] RdM,
  input  logic              RegWriteM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteW,
  input  logic              MemStallM,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              StallW,
  output logic              FlushD,
  output logic              FlushE,
  output logic              LongWrEn,
  output logic [REG_AW-1:0] LongRdW
);

  localparam int unsigned CNT_W = $clog2(LONG_LAT + 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [REG_AW-1:0] pend_rd_q, pend_rd_d;
  logic              issue, busy;
  logic              lw_stall, sb_stall, raw_stall, d_stall;

  // Register match with write enable; x0 never matches.
  function automatic logic hit(input logic [REG_AW-1:0] a,
                               input logic [REG_AW-1:0] b,
                               input logic              en);
    return en && (a != '0) && (a == b);
  endfunction

  // Bypass select for one E-stage source; M has priority over W.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                         input logic [REG_AW-1:0] rd_m,
                                         input logic              we_m,
                                         input logic [REG_AW-1:0] rd_w,
                                         input logic              we_w);
    if (hit(rs, rd_m, we_m))      return 2'b10;
    else if (hit(rs, rd_w, we_w)) return 2'b01;
    else                          return 2'b00;
  endfunction

  // Scoreboard state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      pend_rd_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      pend_rd_q <= pend_rd_d;
    end
  end

  // Scoreboard next state: issue reloads, otherwise count down to zero
  // regardless of the memory freeze.
  always_comb begin
    cnt_d     = cnt_q;
    pend_rd_d = pend_rd_q;
    if (issue) begin
      cnt_d     = CNT_W'(LONG_LAT);
      pend_rd_d = RdE;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  assign issue    = LongOpE & ~MemStallM;
  assign busy     = cnt_q > CNT_W'(1);
  assign LongWrEn = (cnt_q == CNT_W'(1));
  assign LongRdW  = pend_rd_q;

  // Hazard detection and stage control.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    raw_stall = 1'b0;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    StallW    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;

    if (FORWARD_EN != 0) begin
      ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
      ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
    end else begin
      raw_stall = hit(Rs1D, RdE, RegWriteE) | hit(Rs1D, RdM, RegWriteM) |
                  hit(Rs1D, RdW, RegWriteW) | hit(Rs2D, RdE, RegWriteE) |
                  hit(Rs2D, RdM, RegWriteM) | hit(Rs2D, RdW, RegWriteW);
    end

    lw_stall = ResultSrcE0 & (hit(Rs1D, RdE, RegWriteE) | hit(Rs2D, RdE, RegWriteE));

    // RAW/WAW against the pending long result, against a long op issuing
    // now, and the single-unit structural hazard.
    sb_stall = (busy & (hit(Rs1D, pend_rd_q, 1'b1) | hit(Rs2D, pend_rd_q, 1'b1) |
                        hit(RdD, pend_rd_q, RegWriteD))) |
               (issue & (hit(Rs1D, RdE, 1'b1) | hit(Rs2D, RdE, 1'b1) |
                         hit(RdD, RdE, 1'b1))) |
               (LongOpD & (busy | issue));

    d_stall = lw_stall | sb_stall | raw_stall;

    if (MemStallM) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      StallW = 1'b1;
    end else begin
      StallF = d_stall;
      StallD = d_stall;
      FlushD = PCSrcE;
      FlushE = d_stall | PCSrcE;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit: forwarding, load-use, long-op
// scoreboard, memory freeze, async reset mid-operation, and FORWARD_EN=0.
module tb_hazard_scoreboard_unit;
  localparam int unsigned AW = 5;

  logic clk = 1'b0;
  logic reset;
  logic [AW-1:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW;
  logic RegWriteD, LongOpD, RegWriteE, ResultSrcE0, LongOpE, PCSrcE;
  logic RegWriteM, RegWriteW, MemStallM;

  logic [1:0] ForwardAE, ForwardBE, nf_ForwardAE, nf_ForwardBE;
  logic StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, LongWrEn;
  logic nf_StallF, nf_StallD, nf_StallE, nf_StallM, nf_StallW;
  logic nf_FlushD, nf_FlushE, nf_LongWrEn;
  logic [AW-1:0] LongRdW, nf_LongRdW;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_unit #(.REG_AW(AW), .LONG_LAT(4), .FORWARD_EN(1)) dut (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .RegWriteD(RegWriteD), .LongOpD(LongOpD), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RegWriteE(RegWriteE), .ResultSrcE0(ResultSrcE0),
    .LongOpE(LongOpE), .PCSrcE(PCSrcE), .RdM(RdM), .RegWriteM(RegWriteM),
    .RdW(RdW), .RegWriteW(RegWriteW), .MemStallM(MemStallM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallF(StallF),
    .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
    .FlushD(FlushD), .FlushE(FlushE), .LongWrEn(LongWrEn), .LongRdW(LongRdW));

  hazard_scoreboard_unit #(.REG_AW(AW), .LONG_LAT(4), .FORWARD_EN(0)) dut_nf (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .RegWriteD(RegWriteD), .LongOpD(LongOpD), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RegWriteE(RegWriteE), .ResultSrcE0(ResultSrcE0),
    .LongOpE(LongOpE), .PCSrcE(PCSrcE), .RdM(RdM), .RegWriteM(RegWriteM),
    .RdW(RdW), .RegWriteW(RegWriteW), .MemStallM(MemStallM),
    .ForwardAE(nf_ForwardAE), .ForwardBE(nf_ForwardBE), .StallF(nf_StallF),
    .StallD(nf_StallD), .StallE(nf_StallE), .StallM(nf_StallM), .StallW(nf_StallW),
    .FlushD(nf_FlushD), .FlushE(nf_FlushE), .LongWrEn(nf_LongWrEn),
    .LongRdW(nf_LongRdW));

  task automatic clr();
    Rs1D = '0; Rs2D = '0; RdD = '0; RegWriteD = 1'b0; LongOpD = 1'b0;
    Rs1E = '0; Rs2E = '0; RdE = '0; RegWriteE = 1'b0; ResultSrcE0 = 1'b0;
    LongOpE = 1'b0; PCSrcE = 1'b0; RdM = '0; RegWriteM = 1'b0;
    RdW = '0; RegWriteW = 1'b0; MemStallM = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clr();
    @(negedge clk); #1;
    checks++; if (LongWrEn !== 1'b0) begin errors++; $display("FAIL rst_longwren got=%b exp=0", LongWrEn); end
    checks++; if (LongRdW !== 5'd0) begin errors++; $display("FAIL rst_longrdw got=%0d exp=0", LongRdW); end
    checks++; if ({StallF, StallD, StallE, StallM, StallW, FlushD, FlushE} !== 7'b0) begin
      errors++; $display("FAIL rst_ctrl got=%b exp=0000000", {StallF, StallD, StallE, StallM, StallW, FlushD, FlushE}); end
    checks++; if ({ForwardAE, ForwardBE} !== 4'b0) begin errors++; $display("FAIL rst_fwd got=%b exp=0000", {ForwardAE, ForwardBE}); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_forwarding();
    @(negedge clk); clr();
    Rs1E = 5; Rs2E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; #1;
    checks++; if (ForwardAE !== 2'b10) begin errors++; $display("FAIL fwd_m_prio_A got=%b exp=10", ForwardAE); end
    checks++; if (ForwardBE !== 2'b10) begin errors++; $display("FAIL fwd_m_prio_B got=%b exp=10", ForwardBE); end
    @(negedge clk); clr();
    Rs1E = 5; RdM = 5; RegWriteM = 0; RdW = 5; RegWriteW = 1; #1;
    checks++; if (ForwardAE !== 2'b01) begin errors++; $display("FAIL fwd_w_only got=%b exp=01", ForwardAE); end
    @(negedge clk); clr();
    Rs1E = 0; Rs2E = 0; RdM = 0; RegWriteM = 1; RdW = 0; RegWriteW = 1; #1;
    checks++; if ({ForwardAE, ForwardBE} !== 4'b0000) begin errors++; $display("FAIL fwd_x0 got=%b exp=0000", {ForwardAE, ForwardBE}); end
    @(negedge clk); clr();
    Rs1E = 5; Rs2E = 6; RdM = 5; RegWriteM = 1; RdW = 6; RegWriteW = 1; #1;
    checks++; if ({ForwardAE, ForwardBE} !== 4'b1001) begin errors++; $display("FAIL fwd_mixed got=%b exp=1001", {ForwardAE, ForwardBE}); end
  endtask

  task automatic test_load_use();
    @(negedge clk); clr();
    ResultSrcE0 = 1; RegWriteE = 1; RdE = 3; Rs1D = 3; RdD = 4; RegWriteD = 1; #1;
    checks++; if ({StallF, StallD, FlushE, FlushD, StallE} !== 5'b11100) begin
      errors++; $display("FAIL lw_stall got=%b exp=11100", {StallF, StallD, FlushE, FlushD, StallE}); end
    @(negedge clk); clr();
    RdM = 3; RegWriteM = 1; Rs1D = 3; RdD = 4; RegWriteD = 1; #1;
    checks++; if (StallD !== 1'b0) begin errors++; $display("FAIL lw_release got=%b exp=0", StallD); end
    @(negedge clk); clr();
    Rs1E = 3; RdW = 3; RegWriteW = 1; #1;
    checks++; if (ForwardAE !== 2'b01) begin errors++; $display("FAIL lw_fwd_w got=%b exp=01", ForwardAE); end
  endtask

  task automatic test_long_raw();
    @(negedge clk); clr();
    LongOpE = 1; RdE = 7; RegWriteE = 1; #1;
    checks++; if (LongWrEn !== 1'b0) begin errors++; $display("FAIL raw_c0_wren got=%b exp=0", LongWrEn); end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); clr();
      Rs1D = 7; RdD = 8; RegWriteD = 1; #1;
      checks++; if ({StallF, StallD, FlushE, LongWrEn} !== 4'b1110) begin
        errors++; $display("FAIL raw_c%0d got=%b exp=1110", c, {StallF, StallD, FlushE, LongWrEn}); end
    end
    @(negedge clk); clr();
    Rs1D = 7; RdD = 8; RegWriteD = 1; #1;
    checks++; if ({LongWrEn, StallD} !== 2'b10) begin errors++; $display("FAIL raw_c4 got=%b exp=10", {LongWrEn, StallD}); end
    checks++; if (LongRdW !== 5'd7) begin errors++; $display("FAIL raw_c4_rd got=%0d exp=7", LongRdW); end
    @(negedge clk); clr(); #1;
    checks++; if (LongWrEn !== 1'b0) begin errors++; $display("FAIL raw_c5_wren got=%b exp=0", LongWrEn); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); clr();
    LongOpE = 1; RdE = 7; RegWriteE = 1; LongOpD = 1; RdD = 8; RegWriteD = 1; Rs1D = 1; Rs2D = 2; #1;
    checks++; if (StallD !== 1'b1) begin errors++; $display("FAIL b2b_struct_c0 got=%b exp=1", StallD); end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); clr();
      LongOpD = 1; RdD = 8; RegWriteD = 1; Rs1D = 1; Rs2D = 2; #1;
      checks++; if (StallD !== 1'b1) begin errors++; $display("FAIL b2b_struct_c%0d got=%b exp=1", c, StallD); end
    end
    @(negedge clk); clr();
    LongOpD = 1; RdD = 8; RegWriteD = 1; Rs1D = 1; Rs2D = 2; #1;
    checks++; if ({LongWrEn, StallD} !== 2'b10) begin errors++; $display("FAIL b2b_release got=%b exp=10", {LongWrEn, StallD}); end
    // second mul x8 issues; addi x8 behind it is a WAW
    @(negedge clk); clr();
    LongOpE = 1; RdE = 8; RegWriteE = 1; Rs1D = 1; RdD = 8; RegWriteD = 1; #1;
    checks++; if ({LongWrEn, StallD} !== 2'b01) begin errors++; $display("FAIL waw_c5 got=%b exp=01", {LongWrEn, StallD}); end
    for (int c = 6; c <= 8; c++) begin
      @(negedge clk); clr();
      Rs1D = 1; RdD = 8; RegWriteD = 1; #1;
      checks++; if (StallD !== 1'b1) begin errors++; $display("FAIL waw_c%0d got=%b exp=1", c, StallD); end
    end
    @(negedge clk); clr();
    Rs1D = 1; RdD = 8; RegWriteD = 1; #1;
    checks++; if ({LongWrEn, StallD} !== 2'b10) begin errors++; $display("FAIL waw_release got=%b exp=10", {LongWrEn, StallD}); end
    checks++; if (LongRdW !== 5'd8) begin errors++; $display("FAIL waw_rd got=%0d exp=8", LongRdW); end
    @(negedge clk); clr();
  endtask

  task automatic test_mem_stall();
    @(negedge clk); clr();
    LongOpE = 1; RdE = 9; RegWriteE = 1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); clr();
      MemStallM = 1; PCSrcE = 1; #1;
      checks++; if ({StallF, StallD, StallE, StallM, StallW, FlushD, FlushE} !== 7'b1111100) begin
        errors++; $display("FAIL mem_freeze_c%0d got=%b exp=1111100", c, {StallF, StallD, StallE, StallM, StallW, FlushD, FlushE}); end
      checks++; if (LongWrEn !== 1'b0) begin errors++; $display("FAIL mem_wren_c%0d got=%b exp=0", c, LongWrEn); end
    end
    // cnt==1 coincides with a new issue: strobe still fires, then reload
    @(negedge clk); clr();
    PCSrcE = 1; LongOpE = 1; RdE = 10; RegWriteE = 1; #1;
    checks++; if ({LongWrEn, LongRdW} !== {1'b1, 5'd9}) begin errors++; $display("FAIL mem_wren_c4 got=%b/%0d exp=1/9", LongWrEn, LongRdW); end
    checks++; if ({StallF, StallD, StallE, StallM, StallW, FlushD, FlushE} !== 7'b0000011) begin
      errors++; $display("FAIL mem_branch_c4 got=%b exp=0000011", {StallF, StallD, StallE, StallM, StallW, FlushD, FlushE}); end
    for (int c = 5; c <= 7; c++) begin
      @(negedge clk); clr(); #1;
      checks++; if (LongWrEn !== 1'b0) begin errors++; $display("FAIL reissue_wren_c%0d got=%b exp=0", c, LongWrEn); end
    end
    @(negedge clk); clr(); #1;
    checks++; if ({LongWrEn, LongRdW} !== {1'b1, 5'd10}) begin errors++; $display("FAIL reissue_c8 got=%b/%0d exp=1/10", LongWrEn, LongRdW); end
    @(negedge clk); clr();
  endtask

  task automatic test_reset_midop();
    @(negedge clk); clr();
    LongOpE = 1; RdE = 11; RegWriteE = 1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); clr();
      Rs2D = 11; #1;
      checks++; if (StallD !== 1'b1) begin errors++; $display("FAIL midrst_pre_c%0d got=%b exp=1", c, StallD); end
    end
    #1 reset = 1'b1;
    #1;
    checks++; if ({StallD, LongWrEn, LongRdW} !== 7'b0) begin
      errors++; $display("FAIL midrst_async got=%b/%b/%0d exp=0/0/0", StallD, LongWrEn, LongRdW); end
    @(negedge clk); reset = 1'b0;
    for (int c = 4; c <= 6; c++) begin
      #1;
      checks++; if ({StallD, LongWrEn} !== 2'b00) begin errors++; $display("FAIL midrst_post_c%0d got=%b exp=00", c, {StallD, LongWrEn}); end
      @(negedge clk);
    end
  endtask

  task automatic test_no_forward();
    clr();
    Rs1E = 5; RdM = 5; RegWriteM = 1; Rs1D = 5; #1;
    checks++; if ({nf_StallD, nf_FlushE, nf_ForwardAE} !== 4'b1100) begin
      errors++; $display("FAIL nf_dep_m got=%b exp=1100", {nf_StallD, nf_FlushE, nf_ForwardAE}); end
    checks++; if ({StallD, ForwardAE} !== 3'b010) begin errors++; $display("FAIL fwd_dep_m got=%b exp=010", {StallD, ForwardAE}); end
    @(negedge clk); clr();
    Rs2D = 6; RdE = 6; RegWriteE = 1; #1;
    checks++; if ({nf_StallD, StallD} !== 2'b10) begin errors++; $display("FAIL nf_dep_e got=%b exp=10", {nf_StallD, StallD}); end
    @(negedge clk); clr();
    Rs1D = 0; RdW = 0; RegWriteW = 1; #1;
    checks++; if (nf_StallD !== 1'b0) begin errors++; $display("FAIL nf_x0 got=%b exp=0", nf_StallD); end
    @(negedge clk); clr();
    Rs1D = 4; RdW = 4; RegWriteW = 0; #1;
    checks++; if (nf_StallD !== 1'b0) begin errors++; $display("FAIL nf_no_we got=%b exp=0", nf_StallD); end
    @(negedge clk); clr();
    Rs1D = 4; RdW = 4; RegWriteW = 1; #1;
    checks++; if (nf_StallD !== 1'b1) begin errors++; $display("FAIL nf_dep_w got=%b exp=1", nf_StallD); end
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_long_raw();
    test_back_to_back();
    test_mem_stall();
    test_reset_midop();
    test_no_forward();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
